multi_mode_ff_bank: RTL and testbench

Parametrised successor to the team's single-bit D/T/JK selector stage. It holds three WIDTH-bit flip-flop banks (D, T, JK) that update in parallel on every enabled clock edge, and drives one registered, mode-selected output word. It adds synchronous parallel load, clock enable, a change-detect strobe and an optional change counter. It sits between the flip-flop primitives and the lab top-level as the reusable sequential datapath element.

---
 rtl/multi_mode_ff_bank.sv | 106 ++++++++++
 tb/tb_multi_mode_ff_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_ff_bank.sv
// Three parallel WIDTH-bit flip-flop banks (D, T, JK) with a registered, mode-selected output,
// a change-detect strobe and, when CHANGE_COUNT_EN is defined, a saturating change counter.
module multi_mode_ff_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [WIDTH-1:0] D_IN,
  input  logic [WIDTH-1:0] T_IN,
  input  logic [WIDTH-1:0] J_IN,
  input  logic [WIDTH-1:0] K_IN,
  input  logic [1:0]       SEL,
  output logic [WIDTH-1:0] T,
  output logic             CHG,
  output logic [CNT_W-1:0] CHG_CNT
);

  logic [WIDTH-1:0] qd_q, qd_d;
  logic [WIDTH-1:0] qt_q, qt_d;
  logic [WIDTH-1:0] qjk_q, qjk_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic             chg_pend_q, chg_pend_d;
  logic             chg_q, chg_d;

  always_comb begin
    qd_d  = qd_q;
    qt_d  = qt_q;
    qjk_d = qjk_q;
    if (LOAD) begin
      qd_d  = LOAD_VAL;
      qt_d  = LOAD_VAL;
      qjk_d = LOAD_VAL;
    end else if (EN) begin
      qd_d  = D_IN;
      qt_d  = qt_q ^ T_IN;
      // JK characteristic equation: Q+ = J & ~Q | ~K & Q
      qjk_d = (J_IN & ~qjk_q) | (~K_IN & qjk_q);
    end
  end

  // Output mux reads the banks as they were before the edge
  always_comb begin
    t_d = qd_q;
    unique case (SEL)
      2'b00:   t_d = qd_q;
      2'b01:   t_d = qt_q;
      2'b10:   t_d = qjk_q;
      default: t_d = qd_q ^ qt_q ^ qjk_q;
    endcase
  end

  // A change of T is noted on the edge it happens and strobed on the following edge
  always_comb begin
    chg_pend_d = (t_d != t_q);
    chg_d      = chg_pend_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      qd_q       <= '0;
      qt_q       <= '0;
      qjk_q      <= '0;
      t_q        <= '0;
      chg_pend_q <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      qd_q       <= qd_d;
      qt_q       <= qt_d;
      qjk_q      <= qjk_d;
      t_q        <= t_d;
      chg_pend_q <= chg_pend_d;
      chg_q      <= chg_d;
    end
  end

  assign T   = t_q;
  assign CHG = chg_q;

`ifdef CHANGE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (chg_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CHG_CNT = cnt_q;
`else
  assign CHG_CNT = '0;
`endif

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench for multi_mode_ff_bank: a reference model pushes expected outputs to a queue
// on each driven step, and they are popped and asserted after the corresponding clock edge.
module tb_multi_mode_ff_bank;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst, en, ld;
  logic [WIDTH-1:0] lv, din, tin, jin, kin;
  logic [1:0]       sel;
  logic [WIDTH-1:0] t_out;
  logic             chg;
  logic [CNT_W-1:0] cnt;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [WIDTH-1:0] t;
    logic             chg;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [WIDTH-1:0] m_qd, m_qt, m_qjk, m_t;
  logic             m_pend, m_chg;
  logic [CNT_W-1:0] m_cnt;

  multi_mode_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RESET(rst), .EN(en), .LOAD(ld), .LOAD_VAL(lv),
    .D_IN(din), .T_IN(tin), .J_IN(jin), .K_IN(kin), .SEL(sel),
    .T(t_out), .CHG(chg), .CHG_CNT(cnt)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [WIDTH-1:0] nt;
    exp_t e;
    if (rst) begin
      m_qd = '0; m_qt = '0; m_qjk = '0; m_t = '0;
      m_pend = 1'b0; m_chg = 1'b0; m_cnt = '0;
    end else begin
      case (sel)
        2'b00:   nt = m_qd;
        2'b01:   nt = m_qt;
        2'b10:   nt = m_qjk;
        default: nt = m_qd ^ m_qt ^ m_qjk;
      endcase
`ifdef CHANGE_COUNT_EN
      if (m_chg && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
`else
      m_cnt = '0;
`endif
      m_chg  = m_pend;
      m_pend = (nt != m_t);
      m_t    = nt;
      if (ld) begin
        m_qd = lv; m_qt = lv; m_qjk = lv;
      end else if (en) begin
        m_qd = din;
        m_qt = m_qt ^ tin;
        for (int i = 0; i < WIDTH; i++) begin
          case ({jin[i], kin[i]})
            2'b00: m_qjk[i] = m_qjk[i];
            2'b01: m_qjk[i] = 1'b0;
            2'b10: m_qjk[i] = 1'b1;
            default: m_qjk[i] = ~m_qjk[i];
          endcase
        end
      end
    end
    e.t = m_t; e.chg = m_chg; e.cnt = m_cnt;
    e.tag = "";
    sb.push_back(e);
  endtask

  task automatic check_t(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: T observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic l, input logic e,
                      input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] tt, input logic [WIDTH-1:0] j,
                      input logic [WIDTH-1:0] k, input logic [1:0] s);
    exp_t x;
    rst = r; ld = l; en = e; lv = v; din = d; tin = tt; jin = j; kin = k; sel = s;
    model_edge();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      x = sb.pop_front();
      check_t({tag, "_t"}, t_out, x.t);
      check_bit({tag, "_chg"}, 32'(chg), 32'(x.chg));
      check_bit({tag, "_cnt"}, 32'(cnt), 32'(x.cnt));
    end
  endtask

  initial begin
    rst = 1'b0; ld = 1'b0; en = 1'b0; lv = '0; din = '0; tin = '0; jin = '0; kin = '0; sel = '0;
    m_qd = '0; m_qt = '0; m_qjk = '0; m_t = '0; m_pend = 1'b0; m_chg = 1'b0; m_cnt = '0;

    // Reset with random inputs
    step("reset", 1, $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), 8'($urandom),
         8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
    check_t("reset_T", t_out, 8'h00);
    check_bit("reset_CHG", 32'(chg), 0);
    check_bit("reset_CNT", 32'(cnt), 0);

    // D path: A5 at edge 1, visible on T after edge 2, CHG after edge 3 for one cycle
    step("d1", 0, 0, 1, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 2'b00);
    step("d2", 0, 0, 1, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 2'b00);
    check_t("d_path_T", t_out, 8'hA5);
    check_bit("d_path_chg_lo", 32'(chg), 0);
    step("d3", 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    check_bit("d_path_chg_hi", 32'(chg), 1);
    step("d4", 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    check_bit("d_path_chg_end", 32'(chg), 0);

    // T and JK banks from a 0F load
    step("tjk_ld", 0, 1, 0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    step("tjk_en", 0, 0, 1, 8'h00, 8'h00, 8'hFF, 8'hF0, 8'h3C, 2'b00);
    step("tjk_s01", 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01);
    check_t("t_bank", t_out, 8'hF0);
    step("tjk_s10", 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10);
    check_t("jk_bank", t_out, 8'hF3);

    // LOAD beats EN
    step("pri_ld", 0, 1, 1, 8'h3C, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b10);
    step("pri_s00", 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    check_t("load_over_en", t_out, 8'h3C);

    // RESET beats LOAD
    step("pri_rst", 1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b11);
    check_t("rst_over_load", t_out, 8'h00);
    step("pri_post", 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11);
    check_t("post_rst_T", t_out, 8'h00);
    check_bit("post_rst_chg", 32'(chg), 0);

    // Mix mode: Qd=FF, Qt=0F, Qjk=33
    step("mix_en", 0, 0, 1, 8'h00, 8'hFF, 8'h0F, 8'h33, 8'h00, 2'b00);
    step("mix_s11", 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11);
    check_t("mix_T", t_out, 8'hC3);

    // Counter: toggle T every cycle from a clean reset
    step("cnt_rst", 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01);
    for (int i = 0; i < 8; i++) begin
      step("cnt_tog", 0, 0, 1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 2'b01);
    end
    check_bit("cnt_chg_held", 32'(chg), 1);
`ifdef CHANGE_COUNT_EN
    check_bit("cnt_saturated", 32'(cnt), 3);
`else
    check_bit("cnt_tied_zero", 32'(cnt), 0);
`endif
    step("cnt_clr", 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    check_bit("cnt_clear", 32'(cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
